// File: rtl/imem_dmem_port_arbiter.sv
// Arbiter that lets the UART loader, instruction fetch and data load/store share one single-port RAM.
// Optional ARB_RR_EN macro: alternate IF/MEM on simultaneous requests instead of fixed MEM > IF.
module imem_dmem_port_arbiter #(
    parameter int AW     = 14,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic            cpuclk,
    input  logic            rst,
    input  logic            uart_done,
    input  logic            uart_we,
    input  logic [AW-1:0]   uart_addr,
    input  logic [DW-1:0]   uart_wdata,
    output logic            cpu_hold,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic [DW-1:0]   if_rdata,
    output logic            if_valid,
    output logic            if_stall,
    input  logic            mem_req,
    input  logic            mem_we,
    input  logic [DW/8-1:0] mem_be,
    input  logic [AW-1:0]   mem_addr,
    input  logic [DW-1:0]   mem_wdata,
    output logic [DW-1:0]   mem_rdata,
    output logic            mem_valid,
    output logic            mem_stall,
    output logic            ram_en,
    output logic [DW/8-1:0] ram_we,
    output logic [AW-1:0]   ram_addr,
    output logic [DW-1:0]   ram_wdata,
    input  logic [DW-1:0]   ram_rdata
);
    // Handshake: a port raises req and holds req/addr/data stable until its valid
    // pulses for one cycle; stall = req & ~valid tells the pipeline to wait.
    // ram_rdata is sampled on the RD_LAT-th rising edge after the issue cycle.
    localparam int BW = DW / 8;
    localparam logic OWN_IF  = 1'b0;
    localparam logic OWN_MEM = 1'b1;

    typedef enum logic [1:0] {S_LOAD, S_IDLE, S_RD} state_t;

    state_t     state;
    logic [1:0] cnt;
    logic       own;
    logic       if_valid_q, mem_valid_q;
`ifdef ARB_RR_EN
    logic       last;
`endif

    logic idle_go, pick_mem, grant_mem, grant_if, store_now, issue_rd;
    logic cap, cap_own;

    always_comb begin
        idle_go = (state == S_IDLE) && uart_done;
`ifdef ARB_RR_EN
        if (if_req && mem_req) pick_mem = (last == OWN_IF);
        else                   pick_mem = mem_req;
`else
        pick_mem = mem_req;
`endif
        grant_mem = idle_go && mem_req && pick_mem;
        grant_if  = idle_go && if_req && !pick_mem;
        store_now = grant_mem && mem_we;
        issue_rd  = grant_if || (grant_mem && !mem_we);
        // Capture edge is one edge before the valid cycle so data and valid align.
        cap     = (issue_rd && (RD_LAT == 1)) || ((state == S_RD) && (cnt == 2'd2));
        cap_own = issue_rd ? grant_mem : own;

        ram_en    = 1'b0;
        ram_we    = '0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (state == S_LOAD) begin
            ram_en    = uart_we;
            ram_we    = {BW{uart_we}};
            ram_addr  = uart_addr;
            ram_wdata = uart_wdata;
        end else if (grant_mem) begin
            ram_en    = 1'b1;
            ram_we    = mem_we ? mem_be : '0;
            ram_addr  = mem_addr;
            ram_wdata = mem_wdata;
        end else if (grant_if) begin
            ram_en    = 1'b1;
            ram_addr  = if_addr;
        end
    end

    always_ff @(posedge cpuclk) begin
        if (rst) begin
            state       <= S_LOAD;
            cpu_hold    <= 1'b1;
            if_valid_q  <= 1'b0;
            mem_valid_q <= 1'b0;
            if_rdata    <= '0;
            mem_rdata   <= '0;
            cnt         <= 2'd0;
            own         <= OWN_MEM;
`ifdef ARB_RR_EN
            last        <= OWN_IF;
`endif
        end else begin
            if_valid_q  <= cap && (cap_own == OWN_IF);
            mem_valid_q <= cap && (cap_own == OWN_MEM);
            if (cap && (cap_own == OWN_IF))  if_rdata  <= ram_rdata;
            if (cap && (cap_own == OWN_MEM)) mem_rdata <= ram_rdata;
`ifdef ARB_RR_EN
            if (grant_mem || grant_if) last <= grant_mem ? OWN_MEM : OWN_IF;
`endif
            case (state)
                S_LOAD: begin
                    if (uart_done) begin
                        state    <= S_IDLE;
                        cpu_hold <= 1'b0;
                    end
                end
                S_IDLE: begin
                    if (!uart_done) begin
                        state    <= S_LOAD;
                        cpu_hold <= 1'b1;
                    end else if (issue_rd) begin
                        state <= S_RD;
                        cnt   <= 2'(RD_LAT);
                        own   <= grant_mem ? OWN_MEM : OWN_IF;
                    end
                end
                S_RD: begin
                    cnt <= cnt - 2'd1;
                    // A read in flight always completes; a dropped uart_done is honoured afterwards.
                    if (cnt == 2'd1) begin
                        if (uart_done) begin
                            state <= S_IDLE;
                        end else begin
                            state    <= S_LOAD;
                            cpu_hold <= 1'b1;
                        end
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

    assign if_valid  = if_valid_q;
    assign mem_valid = mem_valid_q || store_now;
    assign if_stall  = if_req && !if_valid;
    assign mem_stall = mem_req && !mem_valid;

endmodule

// File: tb/tb_imem_dmem_port_arbiter.sv
// Directed bench for imem_dmem_port_arbiter: instance a uses RD_LAT=1 with a comb-read RAM,
// instance b uses RD_LAT=3 with a preloaded RAM delivering data two edges after issue.
module tb_imem_dmem_port_arbiter;
    logic clk;
    logic rst;

    logic        uart_done, uart_we;
    logic [13:0] uart_addr;
    logic [31:0] uart_wdata;
    logic        cpu_hold;
    logic        if_req;
    logic [13:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid, if_stall;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_valid, mem_stall;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [13:0] ram_addr;
    logic [31:0] ram_wdata, ram_rdata;

    logic        b_uart_done, b_uart_we;
    logic [13:0] b_uart_addr;
    logic [31:0] b_uart_wdata;
    logic        b_cpu_hold;
    logic        b_if_req;
    logic [13:0] b_if_addr;
    logic [31:0] b_if_rdata;
    logic        b_if_valid, b_if_stall;
    logic        b_mem_req, b_mem_we;
    logic [3:0]  b_mem_be;
    logic [13:0] b_mem_addr;
    logic [31:0] b_mem_wdata, b_mem_rdata;
    logic        b_mem_valid, b_mem_stall;
    logic        b_ram_en;
    logic [3:0]  b_ram_we;
    logic [13:0] b_ram_addr;
    logic [31:0] b_ram_wdata, b_ram_rdata;

    int checks = 0;
    int failures = 0;

    imem_dmem_port_arbiter #(.AW(14), .DW(32), .RD_LAT(1)) dut_a (
        .cpuclk(clk), .rst(rst), .uart_done(uart_done), .uart_we(uart_we),
        .uart_addr(uart_addr), .uart_wdata(uart_wdata), .cpu_hold(cpu_hold),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .if_stall(if_stall), .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_valid(mem_valid), .mem_stall(mem_stall), .ram_en(ram_en), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    imem_dmem_port_arbiter #(.AW(14), .DW(32), .RD_LAT(3)) dut_b (
        .cpuclk(clk), .rst(rst), .uart_done(b_uart_done), .uart_we(b_uart_we),
        .uart_addr(b_uart_addr), .uart_wdata(b_uart_wdata), .cpu_hold(b_cpu_hold),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_valid(b_if_valid),
        .if_stall(b_if_stall), .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_be(b_mem_be),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
        .mem_valid(b_mem_valid), .mem_stall(b_mem_stall), .ram_en(b_ram_en), .ram_we(b_ram_we),
        .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata)
    );

    // RAM a: byte-enabled write on the edge, combinational read.
    logic [31:0] ram_a [0:15];
    always @(posedge clk) begin
        if (ram_en) begin
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) ram_a[ram_addr[3:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
    end
    assign ram_rdata = ram_a[ram_addr[3:0]];

    // RAM b: read-only, two register stages after the address.
    logic [31:0] ram_b [0:15];
    logic [31:0] b_s1, b_s2;
    always @(posedge clk) begin
        b_s1 <= ram_b[b_ram_addr[3:0]];
        b_s2 <= b_s1;
    end
    assign b_ram_rdata = b_s2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    logic [13:0] ld_addr [0:4];
    logic [31:0] ld_data [0:4];
    logic        first_if;
    logic [13:0] exp_first_addr, exp_second_addr;

    initial begin
        for (int k = 0; k < 16; k++) ram_b[k] = 32'hB0 + 32'(k);
        ld_addr[0] = 14'd0; ld_data[0] = 32'hA0;
        ld_addr[1] = 14'd1; ld_data[1] = 32'hA1;
        ld_addr[2] = 14'd2; ld_data[2] = 32'hA2;
        ld_addr[3] = 14'd3; ld_data[3] = 32'hA3;
        ld_addr[4] = 14'd5; ld_data[4] = 32'hFFFF_FFFF;
`ifdef ARB_RR_EN
        first_if = 1'b1;
`else
        first_if = 1'b0;
`endif
        exp_first_addr  = first_if ? 14'd0 : 14'd5;
        exp_second_addr = first_if ? 14'd5 : 14'd0;

        rst = 1'b1;
        uart_done = 0; uart_we = 0; uart_addr = '0; uart_wdata = '0;
        if_req = 0; if_addr = '0; mem_req = 0; mem_we = 0; mem_be = '0;
        mem_addr = '0; mem_wdata = '0;
        b_uart_done = 1; b_uart_we = 0; b_uart_addr = '0; b_uart_wdata = '0;
        b_if_req = 0; b_if_addr = '0; b_mem_req = 0; b_mem_we = 0; b_mem_be = '0;
        b_mem_addr = '0; b_mem_wdata = '0;
        step();
        rst = 1'b0;
        sample();
        check("rst_cpu_hold", cpu_hold, 1);
        check("rst_if_valid", if_valid, 0);
        check("rst_mem_valid", mem_valid, 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_mem_rdata", mem_rdata, 0);
        check("rst_ram_en", ram_en, 0);

        // Loader writes pass straight through to the RAM.
        for (int i = 0; i < 5; i++) begin
            uart_we = 1; uart_addr = ld_addr[i]; uart_wdata = ld_data[i];
            sample();
            check("load_ram_en", ram_en, 1);
            check("load_ram_we", ram_we, 4'hF);
            check("load_ram_addr", ram_addr, ld_addr[i]);
            check("load_ram_wdata", ram_wdata, ld_data[i]);
            check("load_cpu_hold", cpu_hold, 1);
            step();
        end
        uart_we = 0;
        if_req = 1; if_addr = 14'd2; mem_req = 1; mem_addr = 14'd1;
        sample();
        check("load_block_en", ram_en, 0);
        check("load_if_stall", if_stall, 1);
        check("load_mem_stall", mem_stall, 1);
        step();
        if_req = 0; mem_req = 0; uart_done = 1;
        sample();
        check("done_hold_still", cpu_hold, 1);
        step();

        // Fetch with RD_LAT=1.
        if_req = 1; if_addr = 14'd2;
        sample();
        check("idle_cpu_hold", cpu_hold, 0);
        check("fetch_ram_en", ram_en, 1);
        check("fetch_ram_addr", ram_addr, 14'd2);
        check("fetch_ram_we", ram_we, 0);
        check("fetch_stall_t", if_stall, 1);
        check("fetch_valid_t", if_valid, 0);
        step();
        sample();
        check("fetch_valid_t1", if_valid, 1);
        check("fetch_rdata", if_rdata, 32'hA2);
        check("fetch_stall_t1", if_stall, 0);
        check("fetch_rd_en", ram_en, 0);
        step();
        if_req = 0;

        // Single-cycle byte-enabled store.
        mem_req = 1; mem_we = 1; mem_be = 4'b0011; mem_addr = 14'd5; mem_wdata = 32'h1234_5678;
        sample();
        check("fetch_valid_t2", if_valid, 0);
        check("store_ram_en", ram_en, 1);
        check("store_ram_we", ram_we, 4'b0011);
        check("store_ram_addr", ram_addr, 14'd5);
        check("store_ram_wdata", ram_wdata, 32'h1234_5678);
        check("store_valid", mem_valid, 1);
        check("store_stall", mem_stall, 0);
        step();
        mem_req = 0; mem_we = 0;

        // Conflict: MEM load beats IF fetch.
        if_req = 1; if_addr = 14'd3; mem_req = 1; mem_addr = 14'd1;
        sample();
        check("store_valid_gone", mem_valid, 0);
        check("conf_ram_addr", ram_addr, 14'd1);
        check("conf_if_stall", if_stall, 1);
        check("conf_mem_stall", mem_stall, 1);
        step();
        sample();
        check("conf_mem_valid", mem_valid, 1);
        check("conf_mem_rdata", mem_rdata, 32'hA1);
        check("conf_if_wait", if_stall, 1);
        step();
        mem_req = 0;
        sample();
        check("conf_if_issue", ram_en, 1);
        check("conf_if_addr", ram_addr, 14'd3);
        check("conf_mem_valid_off", mem_valid, 0);
        step();
        sample();
        check("conf_if_valid", if_valid, 1);
        check("conf_if_rdata", if_rdata, 32'hA3);
        step();
        if_req = 0;

        // Store grants MEM, then a second conflict: round-robin picks IF, fixed picks MEM.
        mem_req = 1; mem_we = 1; mem_be = 4'hF; mem_addr = 14'd6; mem_wdata = 32'h55;
        sample();
        check("store2_valid", mem_valid, 1);
        step();
        mem_we = 0; mem_addr = 14'd5; if_req = 1; if_addr = 14'd0;
        sample();
        check("conf2_first_addr", ram_addr, exp_first_addr);
        step();
        sample();
        check("conf2_first_if_valid", if_valid, first_if);
        check("conf2_first_mem_valid", mem_valid, !first_if);
        step();
        if_req = !first_if; mem_req = first_if;
        sample();
        check("conf2_second_addr", ram_addr, exp_second_addr);
        step();
        sample();
        check("conf2_second_if_valid", if_valid, !first_if);
        check("conf2_second_mem_valid", mem_valid, first_if);
        check("conf2_if_rdata", if_rdata, 32'hA0);
        check("conf2_mem_rdata", mem_rdata, 32'hFFFF_5678);
        step();
        if_req = 0; mem_req = 0;

        // uart_done falls while a read is in flight.
        if_req = 1; if_addr = 14'd1;
        sample();
        check("fall_issue", ram_en, 1);
        step();
        uart_done = 0;
        sample();
        check("fall_valid", if_valid, 1);
        check("fall_rdata", if_rdata, 32'hA1);
        check("fall_hold_rd", cpu_hold, 0);
        step();
        if_addr = 14'd0;
        sample();
        check("fall_hold_load", cpu_hold, 1);
        check("fall_no_issue", ram_en, 0);
        check("fall_if_stall", if_stall, 1);
        step();
        if_req = 0;

        // RD_LAT=3: back-to-back fetches issue at t and t+4.
        b_if_req = 1; b_if_addr = 14'd4;
        sample();
        check("b_hold", b_cpu_hold, 0);
        check("b_issue_t", b_ram_en, 1);
        check("b_addr_t", b_ram_addr, 14'd4);
        for (int c = 1; c < 3; c++) begin
            step();
            sample();
            check("b_wait_valid", b_if_valid, 0);
            check("b_wait_stall", b_if_stall, 1);
            check("b_wait_en", b_ram_en, 0);
        end
        step();
        sample();
        check("b_valid_t3", b_if_valid, 1);
        check("b_rdata_t3", b_if_rdata, 32'hB4);
        check("b_stall_t3", b_if_stall, 0);
        check("b_en_t3", b_ram_en, 0);
        step();
        b_if_addr = 14'd7;
        sample();
        check("b_issue_t4", b_ram_en, 1);
        check("b_addr_t4", b_ram_addr, 14'd7);
        for (int c = 5; c < 7; c++) begin
            step();
            sample();
            check("b_wait2_valid", b_if_valid, 0);
        end
        step();
        sample();
        check("b_valid_t7", b_if_valid, 1);
        check("b_rdata_t7", b_if_rdata, 32'hB7);
        step();
        b_if_req = 0;

        // Reset during RD aborts the read with no valid pulse.
        b_if_req = 1; b_if_addr = 14'd2;
        sample();
        check("b_rst_issue", b_ram_en, 1);
        step();
        rst = 1;
        step();
        rst = 0; b_if_req = 0;
        sample();
        check("b_rst_valid", b_if_valid, 0);
        check("b_rst_hold", b_cpu_hold, 1);
        check("b_rst_rdata", b_if_rdata, 32'hB7 & 32'h0);
        step();
        sample();
        check("b_rst_no_late_valid", b_if_valid, 0);
        step();
        sample();
        check("b_rst_no_late_valid2", b_if_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
